tff_bank_ctrl: RTL and testbench

- Sequencer for a bank of WIDTH toggle flip-flops (t/q/clk/rstn cells) that form a register.
- Per step, drives each cell's t input so the bank walks a selected code sequence: binary up, binary down, Gray, or walking toggle.
- Reads bank q back and, optionally, checks it against the expected value.
- Sits beside the T_FF bank. Software/test logic starts a run and waits for done.

---
 rtl/tff_bank_ctrl_if.sv | 27 ++
 rtl/tff_bank_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tff_bank_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tff_bank_ctrl_if.sv
// Purpose: groups the run-control, status and T_FF bank signals of tff_bank_ctrl.
// Latency: none, this file only bundles signals.
// Backpressure: none. The master drives start/stop/mode/limit/q_in and the slave (the controller) drives t_out/busy/done/err/step_cnt.
interface tff_bank_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;     // one-cycle run request
    logic             stop;      // early-termination request (level)
    logic [1:0]       mode;      // 00 up, 01 down, 10 Gray, 11 walking
    logic [WIDTH-1:0] limit;     // number of steps to run
    logic [WIDTH-1:0] q_in;      // q outputs of the T_FF bank
    logic [WIDTH-1:0] t_out;     // t inputs of the T_FF bank
    logic             busy;      // run in progress
    logic             done;      // one-cycle end-of-run pulse
    logic             err;       // read-back mismatch flag
    logic [WIDTH-1:0] step_cnt;  // steps completed

    modport master (
        output start, stop, mode, limit, q_in,
        input  t_out, busy, done, err, step_cnt
    );

    modport slave (
        input  start, stop, mode, limit, q_in,
        output t_out, busy, done, err, step_cnt
    );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Purpose: drives the t inputs of a WIDTH-cell T_FF bank so it walks an up, down, Gray or walking-toggle sequence.
// Latency: done rises 3+2*L clocks after the edge that launches start, where L is the number of steps; one step every 2 clocks.
// Backpressure: start is ignored while busy; stop ends the run at the next decision point (CLR_CHK or CHECK).
//
// Ports: clk (shared with the bank), rstn (async active-low), bus (tff_bank_ctrl_if.slave):
//   start/stop/mode/limit in, q_in in from the bank, t_out out to the bank, busy/done/err/step_cnt status.
// Optional macro TFF_BANK_CTRL_CHECK_EN: compares q_in with the expected code and raises a sticky err on mismatch.
// When the macro is not defined, err stays 0. The state sequence and the timing are the same in both builds.
module tff_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rstn,
    tff_bank_ctrl_if.slave bus
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CLR_CHK,
        S_ISSUE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] exp_q, exp_d;     // code the bank should hold after the last issued step
    logic [WIDTH-1:0] n_q, n_d;         // step index driving the Gray code
    logic [PW-1:0]    wpos_q, wpos_d;   // n mod WIDTH, kept as a wrapping counter
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             stop_q, stop_d;   // remembers a stop seen since acceptance

    logic             stop_req;
    logic             mismatch;
    logic [WIDTH-1:0] n_nx, cnt_nx, src_n, gray_in, one_hot, mask;
    logic [PW-1:0]    wpos_nx, src_w;

    assign stop_req = stop_q | bus.stop;
    assign n_nx     = n_q + WIDTH'(1);
    assign cnt_nx   = cnt_q + WIDTH'(1);
    assign wpos_nx  = (wpos_q == PW'(WIDTH - 1)) ? '0 : wpos_q + PW'(1);

    // Toggle mask for the next step. In CHECK the step index has not been
    // committed yet, so the incremented values are used.
    always_comb begin
        src_n   = (state_q == S_CHECK) ? n_nx : n_q;
        src_w   = (state_q == S_CHECK) ? wpos_nx : wpos_q;
        gray_in = src_n + WIDTH'(1);
        one_hot = '0;
        one_hot[src_w] = 1'b1;
        case (mode_q)
            2'b00:   mask = exp_q ^ (exp_q + WIDTH'(1));
            2'b01:   mask = exp_q ^ (exp_q - WIDTH'(1));
            2'b10:   mask = exp_q ^ (gray_in ^ (gray_in >> 1));
            default: mask = one_hot;
        endcase
    end

`ifdef TFF_BANK_CTRL_CHECK_EN
    always_comb begin
        mismatch = 1'b0;
        if (state_q == S_CLR_CHK) begin
            mismatch = (bus.q_in != '0);
        end else if (state_q == S_CHECK) begin
            mismatch = (bus.q_in != exp_q);
        end
    end
`else
    assign mismatch = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        t_d     = '0;          // t is a single-cycle pulse unless a state loads it
        exp_d   = exp_q;
        n_d     = n_q;
        wpos_d  = wpos_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stop_d  = stop_q;
        if (state_q != S_IDLE) begin
            stop_d = stop_req;
        end
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    limit_d = bus.limit;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    exp_d   = '0;
                    n_d     = '0;
                    wpos_d  = '0;
                    stop_d  = bus.stop;   // start+stop together still ends at CLR_CHK
                    t_d     = bus.q_in;   // toggling every set bit drives the bank to 0
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_CLR_CHK;
            end
            S_CLR_CHK: begin
                if (mismatch) begin
                    err_d = 1'b1;
                end
                if (mismatch || (limit_q == '0) || stop_req) begin
                    state_d = S_DONE;
                end else begin
                    t_d     = mask;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                exp_d   = exp_q ^ t_q;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                cnt_d  = cnt_nx;
                n_d    = n_nx;
                wpos_d = wpos_nx;
                if (mismatch) begin
                    err_d = 1'b1;
                end
                if (mismatch || (cnt_nx == limit_q) || stop_req) begin
                    state_d = S_DONE;
                end else begin
                    t_d     = mask;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            limit_q <= '0;
            t_q     <= '0;
            exp_q   <= '0;
            n_q     <= '0;
            wpos_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            t_q     <= t_d;
            exp_q   <= exp_d;
            n_q     <= n_d;
            wpos_q  <= wpos_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stop_q  <= stop_d;
        end
    end

    // busy and done decode the state register directly, so a reset clears them at once.
    assign bus.t_out    = t_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = err_q;
    assign bus.step_cnt = cnt_q;
endmodule

// File: tb/tb_tff_bank_ctrl.sv
`timescale 1ns/1ps
module tb_tff_bank_ctrl;
    localparam int W = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    tff_bank_ctrl_if #(.WIDTH(W)) bus();
    tff_bank_ctrl #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    // Behavioural T_FF bank with a preset port and an optional stuck-at-0 read-back.
    logic [W-1:0] bank;
    logic [W-1:0] preset_val = '0;
    logic         preset_en  = 1'b1;
    logic [W-1:0] stuck_mask = '0;
    always @(posedge clk) begin
        if (preset_en) bank <= preset_val;
        else           bank <= bank ^ bus.t_out;
    end
    assign bus.q_in = bank & ~stuck_mask;

    typedef struct {
        logic [W-1:0] t;
        logic         busy;
        logic         done;
        logic [W-1:0] cnt;
        logic         err;
        logic [W-1:0] q;
    } exp_t;

    exp_t         expq[$];
    exp_t         ce;
    logic [W-1:0] mq;          // model's view of the bank contents
    int           n_chk  = 0;
    int           n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Code held by the bank after k steps of a run in mode m, starting from 0.
    function automatic logic [W-1:0] code(input int m, input int k);
        logic [W-1:0] v;
        int           kk;
        v  = '0;
        kk = k % (1 << W);
        case (m)
            0:       v = W'(kk);
            1:       v = W'(-kk);
            2:       v = W'(kk ^ (kk >> 1));
            default: for (int i = 0; i < k; i++) v[i % W] = ~v[i % W];
        endcase
        return v;
    endfunction

    // One compare process: pops one expected cycle per falling edge while a run is traced.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            ce = expq.pop_front();
            chk("t_out",    bus.t_out,    ce.t);
            chk("busy",     bus.busy,     ce.busy);
            chk("done",     bus.done,     ce.done);
            chk("step_cnt", bus.step_cnt, ce.cnt);
            chk("err",      bus.err,      ce.err);
            chk("bank_q",   bank,         ce.q);
        end
    end

    task automatic push(input logic [W-1:0] t, input logic b, input logic d,
                        input logic [W-1:0] c, input logic e, input logic [W-1:0] q);
        exp_t x;
        x.t = t; x.busy = b; x.done = d; x.cnt = c; x.err = e; x.q = q;
        expq.push_back(x);
    endtask

    task automatic preset(input logic [W-1:0] v);
        @(posedge clk); #1;
        preset_en  = 1'b1;
        preset_val = v;
        @(posedge clk); #1;
        preset_en  = 1'b0;
        mq         = v;
    endtask

    // stop_step: -1 none, 0 with start, s>0 one-cycle pulse during ISSUE of step s.
    // noise: pulse start while busy and change mode/limit mid-run. exp_lat < 0 skips the latency check.
    task automatic run(input int m, input int lim, input int stop_step, input bit noise, input int exp_lat);
        int   len, cyc;
        logic e;
        len = lim;
        if (stop_step >= 0 && stop_step < len) len = stop_step;
        e = 1'b0;
`ifdef TFF_BANK_CTRL_CHECK_EN
        for (int k = 1; k <= len; k++) begin
            if ((code(m, k) & ~stuck_mask) != code(m, k)) begin
                len = k;
                e   = 1'b1;
            end
        end
`endif
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode  = 2'(m);
        bus.limit = W'(lim);
        bus.stop  = (stop_step == 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = ~2'(m);
        bus.limit = ~W'(lim);
        push(mq, 1'b1, 1'b0, '0, 1'b0, mq);          // CLR
        push('0, 1'b1, 1'b0, '0, 1'b0, '0);          // CLR_CHK
        for (int k = 0; k < len; k++) begin
            push(code(m, k) ^ code(m, k + 1), 1'b1, 1'b0, W'(k), 1'b0, code(m, k));  // ISSUE
            push('0, 1'b1, 1'b0, W'(k), 1'b0, code(m, k + 1));                      // CHECK
        end
        push('0, 1'b1, 1'b1, W'(len), e, code(m, len));   // DONE
        push('0, 1'b0, 1'b0, W'(len), e, code(m, len));   // back in IDLE
        mq  = code(m, len);
        cyc = 0;
        forever begin
            if (bus.done) break;
            if (cyc > 100) begin
                chk("done_timeout", 32'(cyc), 32'(3 + 2 * len));
                expq.delete();
                break;
            end
            bus.stop  = (stop_step > 0) && (cyc == 2 * stop_step);
            bus.start = noise && (cyc % 3 == 1);
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        if (exp_lat >= 0) chk("latency", 32'(cyc + 1), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 2'b00;
        bus.limit = '0;
        mq        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_t_out", bus.t_out, 0);
        chk("rst_busy",  bus.busy,  0);
        chk("rst_done",  bus.done,  0);
        chk("rst_err",   bus.err,   0);
        chk("rst_cnt",   bus.step_cnt, 0);
        bus.stop = 1'b1;            // stop while idle has no effect
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("idle_stop_busy", bus.busy, 0);
        bus.stop = 1'b0;

        preset(4'b1010);
        run(0, 5, -1, 1'b0, 13);
        chk("up_q",   bank, 4'b0101);
        chk("up_cnt", bus.step_cnt, 5);
        chk("up_err", bus.err, 0);

        preset(4'b0000);
        run(1, 3, -1, 1'b0, 9);
        chk("down_q",   bank, 4'b1101);
        chk("down_cnt", bus.step_cnt, 3);

        run(2, 4, -1, 1'b0, 11);
        chk("gray_q", bank, 4'b0110);
        run(3, 5, -1, 1'b0, 13);
        chk("walk_q", bank, 4'b1110);

        run(0, 0, -1, 1'b0, 3);
        chk("lim0_cnt", bus.step_cnt, 0);

        run(0, 10, 2, 1'b0, 7);
        chk("stop_cnt", bus.step_cnt, 2);
        chk("stop_q",   bank, 4'b0010);

        run(0, 10, 0, 1'b0, 3);
        chk("startstop_cnt", bus.step_cnt, 0);

        run(0, 6, -1, 1'b1, 15);
        chk("busy_start_cnt", bus.step_cnt, 6);
        chk("busy_start_q",   bank, 4'b0110);

        preset(4'b0000);
        stuck_mask = 4'b0010;
        run(0, 8, -1, 1'b0, -1);
`ifdef TFF_BANK_CTRL_CHECK_EN
        chk("chk_err", bus.err, 1);
        chk("chk_cnt", bus.step_cnt, 2);
`else
        chk("chk_err", bus.err, 0);
        chk("chk_cnt", bus.step_cnt, 8);
`endif
        stuck_mask = 4'b0000;
        preset(4'b0000);
        run(0, 1, -1, 1'b0, 5);
        chk("err_cleared", bus.err, 0);

        // Reset during the CHECK cycle of step 2.
        preset(4'b0000);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        bus.limit = 4'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", bus.busy, 1);
        chk("pre_rst_cnt",  bus.step_cnt, 1);
        chk("pre_rst_q",    bank, 4'b0010);
        rstn = 1'b0;
        #1;
        chk("mid_rst_t_out", bus.t_out, 0);
        chk("mid_rst_busy",  bus.busy, 0);
        chk("mid_rst_done",  bus.done, 0);
        chk("mid_rst_cnt",   bus.step_cnt, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_t_out", bus.t_out, 0);
            chk("post_rst_busy",  bus.busy, 0);
            chk("post_rst_q",     bank, 4'b0010);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
